rams_sp_param: RTL and testbench
================================

Name: rams_sp_param

Overview:
Parametrised single-port synchronous RAM. It is the next generation of the team's fixed 64x16 enable-gated RAM, generalised in width and depth. It adds per-byte write enables, a selectable read-during-write mode, an optional output pipeline register, a valid strobe, and a hardware clear sequencer that initialises every word after reset or on request. It is used as a local scratch/buffer memory inside datapath blocks.

Parameters:
DWIDTH, 16, data width in bits; must be a multiple of 8; NBYTES = DWIDTH/8.
AWIDTH, 6, address width; DEPTH = 2**AWIDTH words.
WMODE, 0, read-during-write mode: 0 read-first, 1 write-first, 2 no-change.
OREG, 0, 1 adds an output register stage (read latency 2 instead of 1).
CLR_ON_RST, 1, 1 runs the clear sequence automatically on reset release.
CLR_VAL, 0, DWIDTH-bit value written to every word by the clear sequence.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
en  in  1  access enable; an access is accepted when en=1 and busy=0
we  in  NBYTES  per-byte write enable; we[i] covers di[8i+7:8i]
a  in  AWIDTH  word address
di  in  DWIDTH  write data
clr  in  1  synchronous clear request, one-cycle pulse
do  out  DWIDTH  read data
do_valid  out  1  one-cycle strobe; do is valid in this cycle
busy  out  1  clear sequence in progress; user accesses ignored

Behaviour:
- Reset (async assert):
  - do=0, do_valid=0, all pipeline stages invalid, clear counter=0.
  - FSM goes to CLEAR if CLR_ON_RST=1 (busy=1), else IDLE (busy=0).
  - Memory contents are not reset by rst; only the sequencer writes them.
- FSM states:
  - IDLE: busy=0. clr=1 -> CLEAR with counter=0; busy=1 from the next cycle.
  - CLEAR: busy=1. Each cycle writes CLR_VAL to address counter and increments it. After writing DEPTH-1 -> IDLE.
  - CLEAR lasts exactly DEPTH cycles; busy drops the cycle after the last write.
  - clr asserted during CLEAR is ignored (no restart).
  - rst asserted mid-CLEAR aborts the sequence. After release it restarts at address 0 (CLR_ON_RST=1) or stays IDLE, leaving memory partially cleared (CLR_ON_RST=0).
- Accepted access (en=1, busy=0) at edge N:
  - Writes: byte i written iff we[i]=1; other bytes keep their value. we=0 means pure read.
  - Read data for address a appears on do with do_valid=1 at edge N+1 (OREG=0) or edge N+2 (OREG=1).
- Read-during-write (any we bit set):
  - WMODE 0: do returns the word as it was before the write.
  - WMODE 1: do returns the post-write merged word (new bytes where we=1, old bytes elsewhere).
  - WMODE 2: do is not updated and do_valid stays 0 for that access.
- Non-accepted cycle (en=0, or busy=1): no memory change, do holds its last value, do_valid=0 for the corresponding slot.
- OREG=1: the pipeline advances every cycle. Back-to-back accesses give back-to-back do_valid pulses in issue order. No stall input.
- Address wrap: a spans exactly DEPTH words, so no out-of-range case exists. The clear counter is AWIDTH+1 bits so completion is detectable.
- Simultaneous clr and en in IDLE: the access is accepted in that cycle; CLEAR begins on the next cycle.

Decomposition:
- Shared package rams_pkg:
  - WMODE encodings (WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2).
  - Clear-FSM state encoding (ST_IDLE, ST_CLEAR).
  - Function computing NBYTES from DWIDTH.
- One sub-module, rams_clr_seq: contains the FSM, counter and busy flag, and drives the internal write port mux. The top level holds the memory array, byte-merge logic, mode select and output pipeline.

Test Plan:
1. Defaults, CLR_VAL=16'hA5A5: release rst -> busy=1 for exactly 64 cycles; then read addresses 0, 31 and 63 -> do=16'hA5A5 each, do_valid pulse one cycle after each access.
2. WMODE=0: write 16'h1234 to addr 5 (we=2'b11), then write 16'hABCD to addr 5 -> second access returns do=16'h1234; a following read returns 16'hABCD.
3. WMODE=1, addr 7 holding 16'h1234: write di=16'hFF00 with we=2'b10 -> do=16'hFF34 next cycle; a re-read gives 16'hFF34.
4. WMODE=2, OREG=1: read addr 3 (16'h0003) then write addr 3 -> one do_valid pulse at the read's edge+2 only; do stays 16'h0003 after the write.
5. OREG=1: four back-to-back reads of addresses 0..3 holding 0x10..0x13 -> do_valid high for 4 consecutive cycles starting 2 cycles after the first access, data 0x10, 0x11, 0x12, 0x13.
6. Assert rst at clear cycle 20, release, then clr pulse mid-run -> sequence restarts at 0, busy stays high for 64 cycles, en accesses during busy leave memory and do unchanged with do_valid=0.

Source files
------------

// File: rtl/rams_pkg.sv
// Shared encodings and helpers for the parametrised single-port RAM family.
package rams_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_e;

    function automatic int nbytes(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/rams_clr_seq.sv
// Clear sequencer: walks every word writing CLR_VAL and owns the RAM write port while busy.
module rams_clr_seq
    import rams_pkg::*;
#(
    parameter int                    AWIDTH     = 6,
    parameter int                    NBYTES     = 2,
    parameter int                    CLR_ON_RST = 1,
    parameter logic [8*NBYTES-1:0]   CLR_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [NBYTES-1:0]     we,
    input  logic [AWIDTH-1:0]     a,
    input  logic [8*NBYTES-1:0]   di,
    output logic                  busy,
    output logic                  acc,
    output logic [NBYTES-1:0]     mem_we,
    output logic [AWIDTH-1:0]     mem_a,
    output logic [8*NBYTES-1:0]   mem_wd
);

    localparam clr_state_e RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    clr_state_e          state_q, state_d;
    logic [AWIDTH:0]     cnt_q, cnt_d;
    logic [AWIDTH:0]     cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_inc;
                // Carry into the extra MSB marks that DEPTH-1 has just been written.
                if (cnt_inc[AWIDTH]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_CLEAR);
        acc    = en & ~busy;
        mem_we = acc ? we : '0;
        mem_a  = a;
        mem_wd = di;
        if (busy) begin
            mem_we = '1;
            mem_a  = cnt_q[AWIDTH-1:0];
            mem_wd = CLR_VAL;
        end
    end

endmodule

// File: rtl/rams_sp_param.sv
// Parametrised single-port RAM with byte enables, read-during-write modes,
// optional output register and a hardware clear sequencer.
module rams_sp_param
    import rams_pkg::*;
#(
    parameter int                  DWIDTH     = 16,
    parameter int                  AWIDTH     = 6,
    parameter int                  WMODE      = 0,
    parameter int                  OREG       = 0,
    parameter int                  CLR_ON_RST = 1,
    parameter logic [DWIDTH-1:0]   CLR_VAL    = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [nbytes(DWIDTH)-1:0]   we,
    input  logic [AWIDTH-1:0]           a,
    input  logic [DWIDTH-1:0]           di,
    input  logic                        clr,
    output logic [DWIDTH-1:0]           dout,
    output logic                        do_valid,
    output logic                        busy
);

    localparam int NBYTES = nbytes(DWIDTH);
    localparam int DEPTH  = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              acc;
    logic [NBYTES-1:0] mem_we;
    logic [AWIDTH-1:0] mem_a;
    logic [DWIDTH-1:0] mem_wd;

    rams_clr_seq #(
        .AWIDTH     (AWIDTH),
        .NBYTES     (NBYTES),
        .CLR_ON_RST (CLR_ON_RST),
        .CLR_VAL    (CLR_VAL)
    ) u_clr_seq (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .we     (we),
        .a      (a),
        .di     (di),
        .busy   (busy),
        .acc    (acc),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (mem_we[i]) begin
                mem[mem_a][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
    end

    logic [DWIDTH-1:0] rd_old, rd_merged, rd_data;
    logic              rd_valid;

    always_comb begin
        rd_old = mem[a];
        for (int i = 0; i < NBYTES; i++) begin
            rd_merged[8*i +: 8] = we[i] ? di[8*i +: 8] : rd_old[8*i +: 8];
        end
        rd_data  = rd_old;
        rd_valid = acc;
        if (acc && (|we)) begin
            if (WMODE == WM_WRITE_FIRST) begin
                rd_data = rd_merged;
            end else if (WMODE == WM_NO_CHANGE) begin
                rd_valid = 1'b0;
            end
        end
    end

    logic [DWIDTH-1:0] out_data;
    logic              out_valid;

    generate
        if (OREG != 0) begin : g_oreg
            logic [DWIDTH-1:0] p_data_q;
            logic              p_valid_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_data_q  <= '0;
                    p_valid_q <= 1'b0;
                end else begin
                    p_valid_q <= rd_valid;
                    if (rd_valid) begin
                        p_data_q <= rd_data;
                    end
                end
            end
            assign out_data  = p_data_q;
            assign out_valid = p_valid_q;
        end else begin : g_noreg
            assign out_data  = rd_data;
            assign out_valid = rd_valid;
        end
    endgenerate

    // dout only moves on a valid slot so it holds through idle/busy cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            do_valid <= 1'b0;
        end else begin
            do_valid <= out_valid;
            if (out_valid) begin
                dout <= out_data;
            end
        end
    end

endmodule

// File: tb/tb_rams_sp_param.sv
// Directed bench: three RAM configurations exercising clear, RDW modes and the output register.
module tb_rams_sp_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic        en   [3];
    logic        clr  [3];
    logic [1:0]  we   [3];
    logic [5:0]  a    [3];
    logic [15:0] di   [3];
    logic [15:0] dout [3];
    logic        dv   [3];
    logic        busy [3];

    int total = 0;
    int bad   = 0;

    rams_sp_param #(.WMODE(0), .OREG(0), .CLR_ON_RST(1), .CLR_VAL(16'hA5A5)) dut0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .we(we[0]), .a(a[0]), .di(di[0]),
        .clr(clr[0]), .dout(dout[0]), .do_valid(dv[0]), .busy(busy[0])
    );
    rams_sp_param #(.WMODE(1), .OREG(0), .CLR_ON_RST(1), .CLR_VAL(16'h0000)) dut1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .we(we[1]), .a(a[1]), .di(di[1]),
        .clr(clr[1]), .dout(dout[1]), .do_valid(dv[1]), .busy(busy[1])
    );
    rams_sp_param #(.WMODE(2), .OREG(1), .CLR_ON_RST(0), .CLR_VAL(16'h0000)) dut2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .we(we[2]), .a(a[2]), .di(di[2]),
        .clr(clr[2]), .dout(dout[2]), .do_valid(dv[2]), .busy(busy[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input int d, input logic [1:0] w, input logic [5:0] addr,
                       input logic [15:0] data);
        en[d] = 1'b1;
        we[d] = w;
        a[d]  = addr;
        di[d] = data;
        step();
        en[d] = 1'b0;
        we[d] = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int quiet;
        logic [5:0] rd_addrs [3];
        rd_addrs[0] = 6'd0;
        rd_addrs[1] = 6'd31;
        rd_addrs[2] = 6'd63;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; clr[i] = 1'b0;
            we[i] = 2'b00; a[i] = '0; di[i] = '0;
        end
        #12;
        chk("rst_dout", dout[0], 16'h0000);
        chk("rst_valid", dv[0], 1'b0);
        chk("rst_busy_clr", busy[0], 1'b1);
        chk("rst_busy_noclr", busy[2], 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Test 1: automatic clear, then read back CLR_VAL
        n = 0;
        while (busy[0] && n < 200) begin
            n++;
            step();
        end
        chk("clear_len", n, 64);
        chk("busy1_done", busy[1], 1'b0);
        chk("busy2_idle", busy[2], 1'b0);
        for (int i = 0; i < 3; i++) begin
            acc(0, 2'b00, rd_addrs[i], 16'h0);
            chk("t1_valid", dv[0], 1'b1);
            chk("t1_data", dout[0], 16'hA5A5);
            step();
            chk("t1_pulse", dv[0], 1'b0);
        end

        // Test 2: read-first
        acc(0, 2'b11, 6'd5, 16'h1234);
        chk("t2_old_clr", dout[0], 16'hA5A5);
        acc(0, 2'b11, 6'd5, 16'hABCD);
        chk("t2_rf_valid", dv[0], 1'b1);
        chk("t2_rf_data", dout[0], 16'h1234);
        acc(0, 2'b00, 6'd5, 16'h0);
        chk("t2_reread", dout[0], 16'hABCD);

        // Test 3: write-first with byte enables
        acc(1, 2'b00, 6'd7, 16'h0);
        chk("t3_clr0", dout[1], 16'h0000);
        acc(1, 2'b11, 6'd7, 16'h1234);
        chk("t3_wf_full", dout[1], 16'h1234);
        acc(1, 2'b10, 6'd7, 16'hFF00);
        chk("t3_wf_valid", dv[1], 1'b1);
        chk("t3_wf_merge", dout[1], 16'hFF34);
        acc(1, 2'b00, 6'd7, 16'h0);
        chk("t3_reread", dout[1], 16'hFF34);
        acc(1, 2'b01, 6'd7, 16'h0056);
        chk("t3_wf_lo", dout[1], 16'hFF56);

        // Test 4: no-change with output register
        acc(2, 2'b11, 6'd3, 16'h0003);
        chk("t4_wr_novalid", dv[2], 1'b0);
        step();
        chk("t4_wr_novalid2", dv[2], 1'b0);
        acc(2, 2'b00, 6'd3, 16'h0);
        chk("t4_lat1", dv[2], 1'b0);
        acc(2, 2'b11, 6'd3, 16'hBEEF);
        chk("t4_lat2_valid", dv[2], 1'b1);
        chk("t4_lat2_data", dout[2], 16'h0003);
        step();
        chk("t4_nc_novalid", dv[2], 1'b0);
        chk("t4_nc_hold", dout[2], 16'h0003);
        step();
        chk("t4_nc_hold2", dout[2], 16'h0003);
        acc(2, 2'b00, 6'd3, 16'h0);
        step();
        chk("t4_written", dout[2], 16'hBEEF);

        // Test 5: back-to-back reads through the output register
        for (int i = 0; i < 4; i++) acc(2, 2'b11, 6'(i), 16'(16'h10 + i));
        step();
        step();
        acc(2, 2'b00, 6'd0, 16'h0);
        chk("t5_first_lat", dv[2], 1'b0);
        for (int i = 1; i < 4; i++) begin
            acc(2, 2'b00, 6'(i), 16'h0);
            chk("t5_valid", dv[2], 1'b1);
            chk("t5_data", dout[2], 16'(16'h10 + i - 1));
        end
        step();
        chk("t5_valid_last", dv[2], 1'b1);
        chk("t5_data_last", dout[2], 16'h0013);
        step();
        chk("t5_drain", dv[2], 1'b0);

        // Test 6: clr with simultaneous access, reset abort, ignored clr, blocked accesses
        clr[0] = 1'b1; en[0] = 1'b1; we[0] = 2'b11; a[0] = 6'd10; di[0] = 16'h1111;
        step();
        clr[0] = 1'b0; en[0] = 1'b0; we[0] = 2'b00;
        chk("t6_busy_on", busy[0], 1'b1);
        chk("t6_acc_valid", dv[0], 1'b1);
        chk("t6_acc_data", dout[0], 16'hA5A5);
        repeat (20) step();
        rst[0] = 1'b1;
        #2;
        chk("t6_rst_dout", dout[0], 16'h0000);
        chk("t6_rst_busy", busy[0], 1'b1);
        step();
        rst[0] = 1'b0;
        en[0] = 1'b1; we[0] = 2'b11; a[0] = 6'd0; di[0] = 16'hDEAD;
        n = 0;
        quiet = 0;
        while (busy[0] && n < 200) begin
            n++;
            if (dv[0] !== 1'b0 || dout[0] !== 16'h0000) quiet++;
            clr[0] = (n == 30);
            step();
        end
        clr[0] = 1'b0; en[0] = 1'b0; we[0] = 2'b00;
        chk("t6_clear_len", n, 64);
        chk("t6_busy_quiet", quiet, 0);
        acc(0, 2'b00, 6'd0, 16'h0);
        chk("t6_addr0", dout[0], 16'hA5A5);
        acc(0, 2'b00, 6'd10, 16'h0);
        chk("t6_addr10", dout[0], 16'hA5A5);
        acc(0, 2'b00, 6'd5, 16'h0);
        chk("t6_addr5", dout[0], 16'hA5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
